// File: rtl/sr_cmd_conditioner_if.sv
// Set/reset command bundle: raw button requests in, conditioned SR pulses and debounced levels out.
// Master drives the raw requests; slave is the conditioner producing S/R.
interface sr_cmd_conditioner_if;
    logic btn_set;
    logic btn_reset;
    logic S;
    logic R;
    logic conflict;
    logic set_level;
    logic reset_level;

    modport master (
        output btn_set, btn_reset,
        input  S, R, conflict, set_level, reset_level
    );

    modport slave (
        input  btn_set, btn_reset,
        output S, R, conflict, set_level, reset_level
    );
endinterface

// File: rtl/sr_cmd_conditioner.sv
// Synchronise + debounce raw set/reset lines, emit one-cycle S/R pulses that are never both high.
// Latency: S/R rise 2+DEBOUNCE_CYCLES edges after a stable input; no backpressure, pulses are fire-and-forget.
module sr_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CONFLICT_MODE   = 0,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                rst,
    sr_cmd_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 is the set line, 1 is the reset line.
    logic [1:0]            w_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_db;
    logic [1:0]            w_db_nxt;
    logic [1:0]            w_edge;
    logic [1:0][CNT_W-1:0] r_cnt;
    logic [1:0][CNT_W-1:0] w_cnt_nxt;
    logic                  w_s_nxt;
    logic                  w_r_nxt;
    logic                  w_conflict_nxt;
    logic                  r_s;
    logic                  r_r;
    logic                  r_conflict;

    assign w_raw = {bus.btn_reset, bus.btn_set};

    always_comb begin
        w_db_nxt  = r_db;
        w_cnt_nxt = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (r_sync2[ch] != r_db[ch]) begin
                if (r_cnt[ch] == CNT_MAX) begin
                    w_db_nxt[ch] = r_sync2[ch];
                end else begin
                    w_cnt_nxt[ch] = r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    // Pulses come from the next debounced level so S/R update on the same edge as the levels.
    assign w_edge = w_db_nxt & ~r_db;

    always_comb begin
        w_conflict_nxt = &w_edge;
        w_s_nxt        = w_edge[0];
        w_r_nxt        = w_edge[1];
        if (w_conflict_nxt) begin
            case (CONFLICT_MODE)
                1: begin
                    w_s_nxt = 1'b1;
                    w_r_nxt = 1'b0;
                end
                2: begin
                    w_s_nxt = 1'b0;
                    w_r_nxt = 1'b1;
                end
                default: begin
                    w_s_nxt = 1'b0;
                    w_r_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_db       <= '0;
            r_cnt      <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_db       <= w_db_nxt;
            r_cnt      <= w_cnt_nxt;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_conflict <= w_conflict_nxt;
        end
    end

    assign bus.S           = r_s;
    assign bus.R           = r_r;
    assign bus.conflict    = r_conflict;
    assign bus.set_level   = r_db[0];
    assign bus.reset_level = r_db[1];
endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner: one instance per CONFLICT_MODE sharing the same stimulus.
module tb_sr_cmd_conditioner;
    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic btn_set   = 1'b0;
    logic btn_reset = 1'b0;
    int   n_pass    = 0;
    int   n_total   = 0;

    sr_cmd_conditioner_if ifc0 ();
    sr_cmd_conditioner_if ifc1 ();
    sr_cmd_conditioner_if ifc2 ();

    assign ifc0.btn_set = btn_set;  assign ifc0.btn_reset = btn_reset;
    assign ifc1.btn_set = btn_set;  assign ifc1.btn_reset = btn_reset;
    assign ifc2.btn_set = btn_set;  assign ifc2.btn_reset = btn_reset;

    sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .CONFLICT_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .CONFLICT_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
    sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .CONFLICT_MODE(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    // {S, R, conflict, set_level, reset_level}
    wire [4:0] o0 = {ifc0.S, ifc0.R, ifc0.conflict, ifc0.set_level, ifc0.reset_level};
    wire [4:0] o1 = {ifc1.S, ifc1.R, ifc1.conflict, ifc1.set_level, ifc1.reset_level};
    wire [4:0] o2 = {ifc2.S, ifc2.R, ifc2.conflict, ifc2.set_level, ifc2.reset_level};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert (!(o0[4] && o0[3])) else $error("FAIL s_and_r mode0 S=1 R=1");
        assert (!(o1[4] && o1[3])) else $error("FAIL s_and_r mode1 S=1 R=1");
        assert (!(o2[4] && o2[3])) else $error("FAIL s_and_r mode2 S=1 R=1");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        exp = 5'b0;
        #2 rst = 1'b1;
        #1;
        n_total++; if (o0 !== exp) $display("FAIL reset_async m0 got %b want %b", o0, exp); else n_pass++;
        n_total++; if (o1 !== exp) $display("FAIL reset_async m1 got %b want %b", o1, exp); else n_pass++;
        n_total++; if (o2 !== exp) $display("FAIL reset_async m2 got %b want %b", o2, exp); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            btn_set   = ~btn_set;
            btn_reset = (k % 3) == 0;
            tick();
            n_total++; if (o0 !== exp) $display("FAIL reset_held k=%0d got %b want %b", k, o0, exp); else n_pass++;
        end
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        #3 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_total++; if (o0 !== exp) $display("FAIL reset_release k=%0d got %b want %b", k, o0, exp); else n_pass++;
        end
    endtask

    task automatic test_clean_set();
        logic [4:0] exp;
        btn_set = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = {(k == 6), 1'b0, 1'b0, (k >= 6), 1'b0};
            n_total++; if (o0 !== exp) $display("FAIL clean_set k=%0d got %b want %b", k, o0, exp); else n_pass++;
        end
        btn_set = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {1'b0, 1'b0, 1'b0, (k < 6), 1'b0};
            n_total++; if (o0 !== exp) $display("FAIL clean_set_fall k=%0d got %b want %b", k, o0, exp); else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        int         pulses;
        pat = 7'b1110110;
        for (int i = 0; i < 7; i++) begin
            btn_set = pat[6 - i];
            tick();
            n_total++; if (o0 !== 5'b0) $display("FAIL bounce k=%0d got %b want %b", i, o0, 5'b0); else n_pass++;
        end
        btn_set = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_total++; if (o0 !== 5'b0) $display("FAIL bounce_tail k=%0d got %b want %b", i, o0, 5'b0); else n_pass++;
        end
        pulses = 0;
        btn_set = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 6) btn_set = 1'b0;
            tick();
            if (o0[4]) pulses++;
        end
        n_total++; if (pulses !== 1) $display("FAIL bounce_hold pulses got %0d want 1", pulses); else n_pass++;
        n_total++; if (o0 !== 5'b0) $display("FAIL bounce_settle got %b want %b", o0, 5'b0); else n_pass++;
    endtask

    task automatic test_conflict();
        logic [4:0] e0, e1, e2;
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            e0 = {1'b0,     1'b0,     (k == 6), (k >= 6), (k >= 6)};
            e1 = {(k == 6), 1'b0,     (k == 6), (k >= 6), (k >= 6)};
            e2 = {1'b0,     (k == 6), (k == 6), (k >= 6), (k >= 6)};
            n_total++; if (o0 !== e0) $display("FAIL conflict_m0 k=%0d got %b want %b", k, o0, e0); else n_pass++;
            n_total++; if (o1 !== e1) $display("FAIL conflict_m1 k=%0d got %b want %b", k, o1, e1); else n_pass++;
            n_total++; if (o2 !== e2) $display("FAIL conflict_m2 k=%0d got %b want %b", k, o2, e2); else n_pass++;
        end
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_total++; if (o0[4:2] !== 3'b0) $display("FAIL conflict_fall k=%0d got %b want %b", k, o0[4:2], 3'b0); else n_pass++;
        end
        n_total++; if (o1 !== 5'b0) $display("FAIL conflict_settle got %b want %b", o1, 5'b0); else n_pass++;
    endtask

    task automatic test_midcount_reset();
        logic [4:0] exp;
        btn_reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_total++; if (o0 !== 5'b0) $display("FAIL midrst_pre k=%0d got %b want %b", k, o0, 5'b0); else n_pass++;
        end
        #3 rst = 1'b1;
        tick();
        n_total++; if (o0 !== 5'b0) $display("FAIL midrst_held got %b want %b", o0, 5'b0); else n_pass++;
        rst = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp = {1'b0, (j == 6), 1'b0, 1'b0, (j >= 6)};
            n_total++; if (o0 !== exp) $display("FAIL midrst_post j=%0d got %b want %b", j, o0, exp); else n_pass++;
        end
        btn_reset = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        n_total++; if (o0 !== 5'b0) $display("FAIL midrst_settle got %b want %b", o0, 5'b0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        btn_set = 1'b1;
        tick();
        n_total++; if (o0 !== 5'b0) $display("FAIL b2b k=1 got %b want %b", o0, 5'b0); else n_pass++;
        btn_reset = 1'b1;
        for (int k = 2; k <= 12; k++) begin
            tick();
            exp = {(k == 6), (k == 7), 1'b0, (k >= 6), (k >= 7)};
            n_total++; if (o0 !== exp) $display("FAIL b2b_m0 k=%0d got %b want %b", k, o0, exp); else n_pass++;
            n_total++; if (o2 !== exp) $display("FAIL b2b_m2 k=%0d got %b want %b", k, o2, exp); else n_pass++;
        end
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        for (int j = 0; j < 10; j++) tick();
    endtask

    initial begin
        test_reset();
        test_clean_set();
        test_bounce();
        test_conflict();
        test_midcount_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
